// File: rtl/bus_memory.sv
// bus_memory: 256x8 RAM filled by a byte-stream loader (LOAD), then shared with the CPU data bus (RUN).
// Latency: bus reads are combinational; loader and strobed CPU writes land on the clk edge, readable next cycle.
// Backpressure: load_ready is high for the whole LOAD phase; RAM_OUT_PORT_EN mirrors RUN writes to 0xFF onto out_port.
module bus_memory (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] addr_bus,
    input  logic       c_ro,
    input  logic       c_ri,
    input  logic       mem_clk,
    inout  wire  [7:0] bus,
    input  logic [7:0] load_data,
    input  logic       load_valid,
    input  logic       load_last,
    output logic       load_ready,
    output logic       cpu_hold,
    output logic [7:0] out_port
);
    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t     state;
    logic [7:0] ptr;
    logic       mem_clk_q;
    logic [7:0] mem [256];
    logic       strobe;
    logic       load_we;
    logic       run_we;

    // Qualifying with reset keeps an in-flight edge from writing while reset is low.
    assign strobe  = mem_clk & ~mem_clk_q;
    assign load_we = reset & (state == ST_LOAD) & load_valid & load_ready;
    assign run_we  = reset & (state == ST_RUN) & strobe & c_ri;

    assign bus = (state == ST_RUN && c_ro && !c_ri) ? mem[addr_bus] : 8'hzz;

    // Storage has no reset so a program survives a CPU reset.
    always_ff @(posedge clk) begin
        if (load_we)
            mem[ptr] <= load_data;
        else if (run_we)
            mem[addr_bus] <= bus;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_LOAD;
            ptr        <= 8'h00;
            mem_clk_q  <= 1'b0;
            load_ready <= 1'b1;
            cpu_hold   <= 1'b1;
        end else begin
            mem_clk_q <= mem_clk;
            if (load_we) begin
                // The byte at 0xFF ends the load so ptr never wraps onto the program start.
                if (load_last || ptr == 8'hFF) begin
                    state      <= ST_RUN;
                    load_ready <= 1'b0;
                    cpu_hold   <= 1'b0;
                end else begin
                    ptr <= ptr + 8'h01;
                end
            end
        end
    end

`ifdef RAM_OUT_PORT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            out_port <= 8'h00;
        else if (run_we && addr_bus == 8'hFF)
            out_port <= bus;
    end
`else
    assign out_port = 8'h00;
`endif

endmodule

// File: tb/tb_bus_memory.sv
// Directed + randomized bench for bus_memory against a queue/array reference model.
module tb_bus_memory;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] addr_bus;
    logic       c_ro;
    logic       c_ri;
    logic       mem_clk;
    wire  [7:0] bus;
    logic [7:0] load_data;
    logic       load_valid;
    logic       load_last;
    logic       load_ready;
    logic       cpu_hold;
    logic [7:0] out_port;

    logic [7:0] drv;
    logic       drv_en;
    assign bus = drv_en ? drv : 8'hzz;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [256];
    bit         ref_known [256];
    logic [7:0] ref_out;
    int         ref_ptr;
    bit         ref_loading;
    int         wr_addrs [$];

    bus_memory dut (
        .clk(clk), .reset(reset), .addr_bus(addr_bus), .c_ro(c_ro), .c_ri(c_ri),
        .mem_clk(mem_clk), .bus(bus), .load_data(load_data), .load_valid(load_valid),
        .load_last(load_last), .load_ready(load_ready), .cpu_hold(cpu_hold), .out_port(out_port)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctrl(input string tag);
        chk({tag, "_load_ready"}, {7'd0, load_ready}, {7'd0, ref_loading});
        chk({tag, "_cpu_hold"}, {7'd0, cpu_hold}, {7'd0, ref_loading});
        chk({tag, "_out_port"}, out_port, ref_out);
    endtask

    // Reset is applied mid-cycle; a strobe is pulsed underneath it to show nothing gets written.
    task automatic do_reset();
        reset = 1'b0;
        #2;
        ref_loading = 1'b1;
        ref_ptr     = 0;
        ref_out     = 8'h00;
        check_ctrl("reset");
        mem_clk = 1'b1;
        tick();
        mem_clk = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        chk("load_ready_pre", {7'd0, load_ready}, 8'd1);
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        ref_mem[ref_ptr]   = d;
        ref_known[ref_ptr] = 1'b1;
        if (last || ref_ptr == 255)
            ref_loading = 1'b0;
        else
            ref_ptr++;
        chk("load_cpu_hold", {7'd0, cpu_hold}, {7'd0, ref_loading});
    endtask

    task automatic read_chk(input logic [7:0] a, input string tag);
        if (ref_known[a]) begin
            addr_bus = a;
            c_ri     = 1'b0;
            c_ro     = 1'b1;
            drv_en   = 1'b0;
            #2;
            chk(tag, bus, ref_mem[a]);
            c_ro = 1'b0;
            tick();
        end
    endtask

    // Data changes after the first strobe cycle, so a second write would be visible.
    task automatic write_run(input logic [7:0] a, input logic [7:0] d, input int hold, input logic both);
        addr_bus = a;
        c_ri     = 1'b1;
        c_ro     = both;
        drv_en   = 1'b1;
        drv      = d;
        mem_clk  = 1'b1;
        #1;
        if (both) chk("both_bus_undriven", bus, d);
        tick();
        for (int h = 1; h < hold; h++) begin
            drv = ~d;
            tick();
        end
        mem_clk = 1'b0;
        c_ri    = 1'b0;
        c_ro    = 1'b0;
        drv_en  = 1'b0;
        tick();
        ref_mem[a]   = d;
        ref_known[a] = 1'b1;
        wr_addrs.push_back(int'(a));
`ifdef RAM_OUT_PORT_EN
        if (a == 8'hFF) ref_out = d;
`endif
        chk("out_port_after_write", out_port, ref_out);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] saved [5];
        reset = 1'b1; addr_bus = 8'h00; c_ro = 1'b0; c_ri = 1'b0; mem_clk = 1'b0;
        load_data = 8'h00; load_valid = 1'b0; load_last = 1'b0; drv = 8'h00; drv_en = 1'b0;
        ref_out = 8'h00; ref_ptr = 0; ref_loading = 1'b1;
        for (int i = 0; i < 256; i++) ref_known[i] = 1'b0;
        #2;
        do_reset();

        // LOAD never drives the bus, even with c_ro high.
        addr_bus = 8'h00; c_ro = 1'b1; drv_en = 1'b1; drv = 8'h5C;
        #2;
        chk("load_no_drive", bus, 8'h5C);
        c_ro = 1'b0; drv_en = 1'b0;
        tick();

        load_byte(8'h1E, 1'b0);
        load_byte(8'h2F, 1'b0);
        load_byte(8'hF0, 1'b1);
        check_ctrl("after_load3");
        read_chk(8'h00, "mem0");
        read_chk(8'h01, "mem1");
        read_chk(8'h02, "mem2");

        addr_bus = 8'h01; c_ro = 1'b0; drv_en = 1'b1; drv = ~ref_mem[1];
        #2;
        chk("bus_z_when_idle", bus, ~ref_mem[1]);
        drv_en = 1'b0;
        tick();

        write_run(8'h10, 8'hA5, 2, 1'b0);
        read_chk(8'h10, "strobe_single_write");

        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom);
            write_run(a, d, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
            read_chk(8'(wr_addrs[$urandom_range(0, wr_addrs.size() - 1)]), "rand_read");
        end

        write_run(8'hFF, 8'h42, 1, 1'b0);
        read_chk(8'hFF, "mem_ff");

        // Loader inputs are ignored in RUN.
        load_valid = 1'b1; load_data = 8'h99; load_last = 1'b1;
        tick();
        tick();
        chk("run_load_ready", {7'd0, load_ready}, 8'd0);
        load_valid = 1'b0; load_last = 1'b0;
        read_chk(8'h00, "run_ignores_loader");

        do_reset();
        addr_bus = 8'h90; c_ri = 1'b1; drv_en = 1'b1; drv = 8'h33; mem_clk = 1'b1;
        tick();
        mem_clk = 1'b0; c_ri = 1'b0; drv_en = 1'b0;
        tick();
        for (int i = 0; i < 256; i++) begin
            if (i == 255) begin
                // Strobe rises in LOAD and stays high into RUN: it must never write.
                addr_bus = 8'h90; c_ri = 1'b1; drv_en = 1'b1; drv = ~ref_mem[8'h90]; mem_clk = 1'b1;
            end
            load_byte(8'($urandom), 1'b0);
        end
        check_ctrl("after_load256");
        tick();
        mem_clk = 1'b0; c_ri = 1'b0; drv_en = 1'b0;
        tick();
        for (int i = 0; i < 256; i++) read_chk(8'(i), "full_load_read");

        addr_bus = 8'h80; c_ri = 1'b1; drv_en = 1'b1; drv = ~ref_mem[8'h80];
        do_reset();
        c_ri = 1'b0; drv_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            saved[i] = 8'($urandom);
            load_byte(saved[i], 1'b0);
        end
        do_reset();
        load_byte(~saved[0], 1'b0);
        load_byte(~saved[1], 1'b1);
        check_ctrl("after_reload");
        for (int i = 0; i < 5; i++) read_chk(8'(i), "reload_read");
        read_chk(8'h80, "no_write_in_reset");
        read_chk(8'h90, "no_write_in_load");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
